// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and width for the counter command sequencer
package counter_ctrl_pkg;

  localparam int WIDTH = 5;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_RUN  = 2'd2,
    OP_STOP = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command sequencer driving a loadable counter's data/load/enable
//
// Ports:
//   clk, rst_            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op, cmd_arg      NOP/LOAD/RUN/STOP and its argument
//   abort                ends a RUN in progress
//   count                counter output fed back for wrap and shadow checking
//   data, load, enable   counter controls
//   busy, done, aborted  sequencer status
//   wrap, err            counter wrap pulse, sticky shadow-mismatch flag
module counter_ctrl #(
  parameter int WIDTH = counter_ctrl_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] data,
  output logic             load,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap,
  output logic             err
);
  import counter_ctrl_pkg::*;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             free_q, free_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_q, load_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             wrap_q, wrap_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0] shadow_q;
  logic             shadow_vld_q;
  logic             err_q;
  logic             accept;

  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    free_d      = free_q;
    data_d      = data_q;
    load_d      = 1'b0;
    enable_d    = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op_e'(cmd_op))
            OP_LOAD: begin
              state_d = S_LOAD;
              load_d  = 1'b1;
              data_d  = cmd_arg;
            end
            OP_RUN: begin
              state_d     = S_RUN;
              enable_d    = 1'b1;
              remaining_d = cmd_arg;
              free_d      = (cmd_arg == '0);
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_RUN: begin
        // remaining_q holds the enabled cycles left including the current one
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (!free_q && remaining_q == ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          enable_d = 1'b1;
          if (!free_q) begin
            remaining_d = remaining_q - ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    // counter steps MAXV->0 on this edge when it is enabled at terminal count
    wrap_d      = enable_q && (count == MAXV);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      free_q      <= 1'b0;
      data_q      <= '0;
      load_q      <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      wrap_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      free_q      <= free_d;
      data_q      <= data_d;
      load_q      <= load_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      wrap_q      <= wrap_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Shadow copy of what the counter should hold; compared only while idle,
  // when the counter is quiescent and fully caught up with its last control.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (state_q == S_IDLE && shadow_vld_q && count != shadow_q) begin
        err_q <= 1'b1;
      end
      if (load_q) begin
        shadow_q     <= data_q;
        shadow_vld_q <= 1'b1;
      end else if (enable_q) begin
        shadow_q <= shadow_q + ONE;
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign data      = data_q;
  assign load      = load_q;
  assign enable    = enable_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - randomized and directed bench for counter_ctrl with a behavioural model
module tb_counter_ctrl;

  localparam int BIG = 1 << 30;

  logic       clk;
  logic       rst_;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_arg;
  logic       abort;
  logic [4:0] count;
  logic [4:0] data;
  logic       load;
  logic       enable;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       wrap;
  logic       err;
  logic       stuck;

  int tests;
  int fails;
  int wraps;

  counter_ctrl dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .count     (count),
    .data      (data),
    .load      (load),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .wrap      (wrap),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counter stub; stuck forces a broken counter reading zero
  initial count = 5'd0;
  always @(posedge clk) begin
    if (stuck)       count <= 5'd0;
    else if (load)   count <= data;
    else if (enable) count <= count + 5'd1;
  end

  always @(negedge clk) if (rst_ && wrap) wraps++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: schedule of cycle windows ----------------
  int cyc;
  int idle_from, busy_from, load_cyc, run_start, run_end;
  int done_cyc, aborted_cyc, wrap_cyc, err_cyc;
  logic [4:0] m_data, m_shadow;
  bit m_sh_vld;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cyc = 0; idle_from = 1; busy_from = 1; load_cyc = -1;
      run_start = -1; run_end = -2; done_cyc = -1; aborted_cyc = -1;
      wrap_cyc = -1; err_cyc = BIG; m_data = 5'd0; m_shadow = 5'd0; m_sh_vld = 0;
    end else begin
      automatic int c = cyc;
      automatic bit en_c = (c >= run_start) && (c <= run_end);
      automatic bit idle_c = !((c >= busy_from) && (c < idle_from));
      if (idle_c && m_sh_vld && count != m_shadow && err_cyc == BIG) err_cyc = c + 1;
      if (c == load_cyc) begin
        m_shadow = m_data; m_sh_vld = 1;
      end else if (en_c) begin
        m_shadow = m_shadow + 5'd1;
      end
      if (en_c && count == 5'd31) wrap_cyc = c + 1;
      if (en_c && abort) begin
        run_end = c; aborted_cyc = c + 1; idle_from = c + 1;
        if (done_cyc > c) done_cyc = -1;
      end else if (c >= idle_from && cmd_valid) begin
        case (cmd_op)
          2'd1: begin
            busy_from = c + 1; idle_from = c + 2; load_cyc = c + 1;
            m_data = cmd_arg; done_cyc = c + 2;
          end
          2'd2: begin
            busy_from = c + 1; run_start = c + 1;
            if (cmd_arg == 5'd0) begin
              run_end = BIG; idle_from = BIG; done_cyc = -1;
            end else begin
              run_end = c + int'(cmd_arg); idle_from = c + int'(cmd_arg) + 1;
              done_cyc = idle_from;
            end
          end
          default: done_cyc = c + 1;
        endcase
      end
      cyc = c + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_) begin
      chk("rst_cmd_ready", cmd_ready, 0); chk("rst_load", load, 0);
      chk("rst_enable", enable, 0);       chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);           chk("rst_aborted", aborted, 0);
      chk("rst_wrap", wrap, 0);           chk("rst_err", err, 0);
      chk("rst_data", data, 0);
    end else begin
      automatic int c = cyc;
      chk("cmd_ready", cmd_ready, c >= idle_from);
      chk("busy", busy, (c >= busy_from) && (c < idle_from));
      chk("load", load, c == load_cyc);
      chk("enable", enable, (c >= run_start) && (c <= run_end));
      chk("done", done, c == done_cyc);
      chk("aborted", aborted, c == aborted_cyc);
      chk("wrap", wrap, c == wrap_cyc);
      chk("err", err, c >= err_cyc);
      chk("data", data, m_data);
      chk("excl_load_enable", load && enable, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] op, input logic [4:0] arg);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    while (!cmd_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) chk("send_timeout", n, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !cmd_ready) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) chk("idle_timeout", n, 0);
  endtask

  int w0;

  initial begin
    tests = 0; fails = 0; wraps = 0; stuck = 1'b0;
    rst_ = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 5'd0; abort = 1'b0;

    // 1: reset release, ready after first edge
    #12 rst_ = 1'b1;
    @(negedge clk);
    chk("ready_after_first_edge", cmd_ready, 1);

    // 2: LOAD 21
    send(2'd1, 5'b10101);
    wait_idle();
    chk("load21_count", count, 21);
    chk("load21_err", err, 0);

    // 3: RUN 5
    send(2'd2, 5'd5);
    wait_idle();
    chk("run5_count", count, 26);
    chk("run5_busy", busy, 0);
    chk("run5_err", err, 0);

    // 4: LOAD 30, RUN 3 wraps once
    send(2'd1, 5'd30);
    wait_idle();
    w0 = wraps;
    send(2'd2, 5'd3);
    wait_idle();
    @(negedge clk);
    chk("wrap_count_final", count, 1);
    chk("wrap_pulses", wraps - w0, 1);

    // 5: free run aborted after 7 enabled cycles, held RUN 2 waits for idle
    send(2'd2, 5'd0);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 5'd2;
    begin
      int n = 0;
      int k = 0;
      while (n < 7 && k < 100) begin
        if (enable) n++;
        if (n < 7) begin
          @(negedge clk); k++;
        end
      end
      chk("abort_enabled_cycles", n, 7);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_no_done", done, 0);
    chk("abort_enable_low", enable, 0);
    chk("abort_count", count, 8);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    chk("held_run_count", count, 10);

    // random phase
    for (int i = 0; i < 40; i++) begin
      automatic logic [1:0] op = 2'($urandom_range(0, 3));
      automatic logic [4:0] arg = (op == 2'd2) ? 5'($urandom_range(0, 12)) : 5'($urandom);
      automatic int n = 0;
      send(op, arg);
      while ((busy || !cmd_ready) && n < 60) begin
        abort = ($urandom_range(0, 9) == 0) || (n > 20);
        @(negedge clk); n++;
      end
      abort = 1'b0;
      if (n >= 60) chk("rand_idle_timeout", n, 0);
      repeat ($urandom_range(0, 3)) begin
        abort = $urandom_range(0, 1) == 1;
        @(negedge clk);
      end
      abort = 1'b0;
    end
    chk("rand_err_clean", err, 0);

    // mid-RUN async reset drops enable without a clock
    send(2'd2, 5'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_ = 1'b0;
    #1;
    chk("async_rst_enable", enable, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk);
    #2 rst_ = 1'b1;
    stuck = 1'b1;

    // 6: stuck counter makes err sticky until reset
    send(2'd1, 5'd10);
    wait_idle();
    @(negedge clk);
    chk("stuck_err_set", err, 1);
    send(2'd0, 5'd0);
    send(2'd2, 5'd2);
    wait_idle();
    chk("stuck_err_sticky", err, 1);
    @(posedge clk);
    #2 rst_ = 1'b0;
    #1;
    chk("err_cleared_by_rst", err, 0);
    @(negedge clk);
    rst_ = 1'b1;
    stuck = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Command sequencer that sits directly upstream of the team's 5-bit loadable counter and drives its data, load and enable inputs. It accepts LOAD, RUN and STOP commands over a valid/ready handshake and sequences them into counter control pulses. It reads the counter's count output back to report wrap-around, completion and shadow-mismatch errors.

Parameters:
WIDTH, 5, counter/data width; all count arithmetic is modulo 2**WIDTH
MAXV, 2**WIDTH-1, terminal count value used for wrap detection (derived, not overridable)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_op  in  2  0=NOP, 1=LOAD, 2=RUN, 3=STOP
cmd_arg  in  WIDTH  LOAD: value; RUN: enabled-cycle count (0 = free run)
abort  in  1  synchronous abort of a RUN in progress
count  in  WIDTH  counter output, fed back
data  out  WIDTH  to counter data
load  out  1  to counter load
enable  out  1  to counter enable
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal command completion
aborted  out  1  one-cycle pulse when a RUN ends by abort
wrap  out  1  one-cycle pulse after the counter wraps MAXV->0
err  out  1  sticky shadow-mismatch flag

Behaviour:
- Reset (rst_ low, async): state IDLE; data, load, enable, done, aborted, wrap, err, cmd_ready = 0; shadow invalid. cmd_ready rises on the first clk edge after rst_ releases. Reset during RUN drops enable immediately, without waiting for a clock.
- All outputs are registered. load and enable are never high in the same cycle.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_ready drops the cycle after acceptance and stays low until the state returns to IDLE. Commands presented while cmd_ready=0 are held, not dropped.
- States: IDLE, LOAD, RUN.
- LOAD accepted at edge T:
  - cycle T+1: load=1, data=cmd_arg; shadow<=cmd_arg; shadow becomes valid.
  - cycle T+2: IDLE, done=1, cmd_ready=1.
- RUN N>=1 accepted at T:
  - enable=1 for cycles T+1..T+N exactly; remaining counter decrements each enabled cycle.
  - cycle T+N+1: IDLE, done=1.
- RUN N=0: free run; enable stays high until abort.
- NOP and STOP in IDLE: no counter activity; done=1 at T+1.
- abort sampled high in RUN at edge E: enable=0 from E onward, IDLE, aborted=1 for one cycle, no done. abort outside RUN is ignored.
- Shadow: on each enabled cycle, shadow<=shadow+1 mod 2**WIDTH.
- wrap: asserted the cycle after a cycle with enable=1 and count==MAXV.
- err: in IDLE with shadow valid, count!=shadow sets err. err clears only on reset.
- Simultaneous events:
  - abort on the final cycle of a finite RUN: abort wins; aborted=1, done=0.
  - cmd_valid during RUN: no acceptance until IDLE.

Decomposition:
- Package counter_ctrl_pkg holds:
  - typedef enum cmd_op_e {OP_NOP, OP_LOAD, OP_RUN, OP_STOP}
  - typedef enum state_e {S_IDLE, S_LOAD, S_RUN}
  - localparam WIDTH
- Single module, no sub-module. The shadow/err checker is one always_ff block inside counter_ctrl.

Test Plan:
1. rst_=0 for 10ns, then rst_=1 -> all outputs 0 during reset; cmd_ready=1 after the first edge; reasserting rst_ mid-RUN drops enable asynchronously.
2. LOAD arg=5'b10101 -> load=1 with data=10101 for exactly one cycle; done one cycle later; count=21; err=0.
3. After test 2, RUN arg=5 -> enable high exactly 5 cycles; done pulse; count=26; busy low afterwards; err=0.
4. LOAD 30, then RUN 3 -> exactly one wrap pulse, on the cycle after count was 31; final count=1; done asserted.
5. RUN arg=0, abort after 7 enabled cycles -> enable drops at the abort edge; aborted=1, done=0; count=start+7; a RUN cmd held valid during the run is accepted only after IDLE.
6. Counter stub with count stuck at 0; LOAD 10 -> err=1 once back in IDLE and stays 1 through further commands; err clears only on rst_.
